// File: rtl/int_chain.sv
// int_chain: cascade of N integrator stages for the CIC decimator chain.
// Each stage adds its input into a wrapping Wout-bit accumulator whenever the
// preceding stage's valid flag is set, so valid tokens move one stage per clock.
// data_out and val_out come directly from the last stage's registers, so no
// input reaches an output combinationally.
module int_chain #(
  parameter int Win  = 19,
  parameter int N    = 3,
  parameter int Wout = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Win-1:0]  data_in,
  input  logic            val_in,
  output logic [Wout-1:0] data_out,
  output logic            val_out
);

  // Stage-0 operand: data_in sign-extended to the accumulator width.
  logic [Wout-1:0] x0;

  generate
    if (Wout > Win) begin : g_sext
      assign x0 = {{(Wout-Win){data_in[Win-1]}}, data_in};
    end else begin : g_same
      assign x0 = data_in;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 1; gi <= N; gi++) begin : stage
      logic [Wout-1:0] acc_reg;
      logic            vld_reg;
      logic [Wout-1:0] x_prev;
      logic            v_prev;

      // Select this stage's operand: the sign-extended sample for the first
      // stage, the previous stage's accumulator and valid flag otherwise.
      if (gi == 1) begin : g_first
        assign x_prev = x0;
        assign v_prev = val_in;
      end else begin : g_chain
        assign x_prev = stage[gi-1].acc_reg;
        assign v_prev = stage[gi-1].vld_reg;
      end

      // Accumulate on a valid token (modulo 2^Wout), hold otherwise; reset wins.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
          vld_reg <= 1'b0;
        end else begin
          vld_reg <= v_prev;
          if (v_prev) begin
            acc_reg <= acc_reg + x_prev;
          end
        end
      end
    end
  endgenerate

  assign data_out = stage[N].acc_reg;
  assign val_out  = stage[N].vld_reg;

endmodule

// File: tb/tb_int_chain.sv
// Self-checking bench for int_chain (N=3, Win=Wout=19): directed scenarios
// with known values plus a randomized run compared every cycle against a
// binomial-sum reference model.
module tb_int_chain;
  localparam int WIN  = 19;
  localparam int N    = 3;
  localparam int WOUT = 19;
  localparam int HMAX = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic [WIN-1:0]  data_in;
  logic            val_in;
  logic [WOUT-1:0] data_out;
  logic            val_out;

  int checks   = 0;
  int failures = 0;

  int_chain #(.Win(WIN), .N(N), .Wout(WOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .val_in   (val_in),
    .data_out (data_out),
    .val_out  (val_out)
  );

  always #5 clk = ~clk;

  // Reference history: per edge, whether reset was applied, whether a sample
  // was accepted, its index in samp[], and the first sample index since reset.
  bit          rst_h [HMAX];
  bit          acc_h [HMAX];
  int          gi_h  [HMAX];
  int          es_h  [HMAX];
  longint      samp  [HMAX];
  int          nsamp       = 0;
  int          epoch_start = 0;
  int          cyc         = 0;
  logic [WOUT-1:0] exp_data = '0;
  logic            exp_val  = 1'b0;

  function automatic longint choose(input int n, input int k);
    longint c = 1;
    for (int j = 1; j <= k; j++) c = c * longint'(n - k + j) / longint'(j);
    return c;
  endfunction

  // N-fold running sum of the samples since reset, expressed in closed form:
  // y[g] = sum_i C(g-i+N-1, N-1) * x[i], truncated to WOUT bits.
  function automatic logic [WOUT-1:0] model_y(input int e);
    longint s = 0;
    for (int i = es_h[e]; i <= gi_h[e]; i++)
      s += choose(gi_h[e] - i + N - 1, N - 1) * samp[i];
    return s[WOUT-1:0];
  endfunction

  task automatic step(input logic r, input logic v, input logic [WIN-1:0] d);
    int  e;
    bit  ok;
    longint sx;
    rst = r; val_in = v; data_in = d;
    @(posedge clk);
    rst_h[cyc] = r;
    acc_h[cyc] = v && !r;
    if (v && !r) begin
      sx = longint'($signed(d));
      samp[nsamp] = sx;
      gi_h[cyc] = nsamp;
      es_h[cyc] = epoch_start;
      nsamp++;
    end
    if (r) epoch_start = nsamp;
    // A token accepted at edge e emerges after edge e+N-1 unless a reset hit.
    e  = cyc - N + 1;
    ok = (e >= 0) && acc_h[(e >= 0) ? e : 0];
    if (ok) for (int t = e; t <= cyc; t++) if (rst_h[t]) ok = 0;
    if (r) begin
      exp_val = 1'b0; exp_data = '0;
    end else if (ok) begin
      exp_val = 1'b1; exp_data = model_y(e);
    end else begin
      exp_val = 1'b0;
    end
    cyc++;
    #1;
    checks++;
    assert (val_out === exp_val) else begin
      failures++;
      $error("FAIL model_val cyc=%0d observed=%0b expected=%0b", cyc, val_out, exp_val);
    end
    checks++;
    assert (data_out === exp_data) else begin
      failures++;
      $error("FAIL model_data cyc=%0d observed=%0d expected=%0d", cyc,
             $signed(data_out), $signed(exp_data));
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [WOUT-1:0] d);
    checks++;
    assert (val_out === v && data_out === d) else begin
      failures++;
      $error("FAIL %s observed val=%0b data=%0d expected val=%0b data=%0d",
             tag, val_out, $signed(data_out), v, $signed(d));
    end
  endtask

  initial begin
    int tri_v [6];
    logic [WOUT-1:0] wrap_v [3];
    logic [WIN-1:0]  neg1;
    tri_v  = '{1, 3, 6, 10, 15, 21};
    wrap_v = '{19'd262143, 19'd262141, 19'h7FFFA};
    neg1   = '1;
    rst = 1'b1; val_in = 1'b0; data_in = '0;

    // Reset held with valid input present: outputs stay at zero.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 19'd5);
      expect_out("reset_hold", 1'b0, '0);
    end
    $display("txn reset_hold done cyc=%0d", cyc);

    // Impulse with continuous valid.
    step(1'b0, 1'b1, 19'd1);
    expect_out("impulse_lat1", 1'b0, '0);
    step(1'b0, 1'b1, 19'd0);
    expect_out("impulse_lat2", 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 19'd0);
      expect_out("impulse", 1'b1, WOUT'(tri_v[i]));
      $display("txn impulse out[%0d]=%0d", i, $signed(data_out));
    end

    // Negative impulse.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, neg1);
    step(1'b0, 1'b1, 19'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 19'd0);
      expect_out("neg_impulse", 1'b1, WOUT'(-tri_v[i]));
      $display("txn neg_impulse out[%0d]=%0d", i, $signed(data_out));
    end

    // Wrap-around at full-scale positive input.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 19'd262143);
    step(1'b0, 1'b1, 19'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 19'd0);
      expect_out("wrap", 1'b1, wrap_v[i]);
      $display("txn wrap out[%0d]=%0d", i, $signed(data_out));
    end

    // Gapped valid: data on invalid cycles is junk and must be ignored.
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) step(1'b0, 1'b1, 19'd1);
      else if (k % 2 == 0) step(1'b0, 1'b1, 19'd0);
      else step(1'b0, 1'b0, WIN'($urandom));
      if (k >= 2) begin
        if (k % 2 == 0) expect_out("gapped_valid", 1'b1, WOUT'(tri_v[(k-2)/2]));
        else expect_out("gapped_hold", 1'b0, WOUT'(tri_v[(k-3)/2]));
      end
      $display("txn gapped k=%0d val_out=%0b data_out=%0d", k, val_out, $signed(data_out));
    end

    // Mid-stream reset with val_in=1, then a fresh impulse.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 19'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 19'd0);
    step(1'b1, 1'b1, 19'd7);
    expect_out("midrst_clear", 1'b0, '0);
    step(1'b0, 1'b1, 19'd1);
    expect_out("midrst_flush1", 1'b0, '0);
    step(1'b0, 1'b1, 19'd0);
    expect_out("midrst_flush2", 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 19'd0);
      expect_out("midrst_restart", 1'b1, WOUT'(tri_v[i]));
      $display("txn midrst out[%0d]=%0d", i, $signed(data_out));
    end

    // Randomized traffic with occasional resets, checked by the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70), WIN'($urandom));
      $display("txn rand %0d val_out=%0b data_out=%0d", i, val_out, $signed(data_out));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
